trigger_out_async: RTL and testbench

//  Trigger transmitter. Takes a trigger request and a sub-period position from the clk80 domain.

---
 rtl/trigger_out_async.sv | 106 ++++++++++
 tb/tb_trigger_out_async.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/trigger_out_async.sv
// trigger_out_async: emits one fixed-width trigger pulse at a clk400-resolved position inside the sync period,
// with a minimum low gap after it so every pulse clears the receiver filter and veto.
module trigger_out_async #(
  parameter int PERIOD = 10,
  parameter int WIDTH  = 5,
  parameter int GAP    = 10
) (
  input  logic       clk400,
  input  logic       reset,
  input  logic       clk80,
  input  logic       sync,
  input  logic       trg_req,
  input  logic [3:0] trg_pos,
  output logic       trigger_out,
  output logic       busy,
  output logic       drop,
  output logic [7:0] drop_cnt
);
  localparam int DW = $clog2(PERIOD > 1 ? PERIOD : 2);
  localparam int WW = $clog2(WIDTH > 1 ? WIDTH : 2);
  localparam int GW = $clog2(GAP > 1 ? GAP : 2);
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE, S_GAP} state_t;
  state_t state_q, state_d;
  logic req80_q, sync1_q, clear_q, trig_q, trig_d, drop_q, drop_d;
  logic [DW-1:0] pos80_q, dcnt_q, dcnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [7:0] cnt_q, cnt_d;
  always_ff @(posedge clk80 or posedge reset)
    if (reset) begin
      req80_q <= 1'b0;
      pos80_q <= '0;
    end else if (sync) begin
      req80_q <= trg_req;
      pos80_q <= (int'(trg_pos) > PERIOD - 1) ? DW'(PERIOD - 1) : DW'(trg_pos);
    end
  // clk400 is phase-locked to clk80, so sampling clk80 as data gives a clean one-cycle period strobe
  always_ff @(posedge clk400 or posedge reset)
    if (reset) begin
      sync1_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      sync1_q <= clk80;
      clear_q <= sync & clk80 & ~sync1_q;
    end
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    trig_d  = trig_q;
    drop_d  = clear_q & req80_q & (state_q != S_IDLE);
    cnt_d   = (drop_d && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
    case (state_q)
      S_IDLE:
        if (clear_q & req80_q) begin
          if (pos80_q == '0) begin
            state_d = S_PULSE;
            trig_d  = 1'b1;
            wcnt_d  = WW'(WIDTH - 1);
          end else begin
            state_d = S_DELAY;
            dcnt_d  = pos80_q - DW'(1);
          end
        end
      S_DELAY:
        if (dcnt_q == '0) begin
          state_d = S_PULSE;
          trig_d  = 1'b1;
          wcnt_d  = WW'(WIDTH - 1);
        end else dcnt_d = dcnt_q - DW'(1);
      S_PULSE:
        if (wcnt_q == '0) begin
          state_d = S_GAP;
          trig_d  = 1'b0;
          gcnt_d  = GW'(GAP - 1);
        end else wcnt_d = wcnt_q - WW'(1);
      S_GAP:
        if (gcnt_q == '0) state_d = S_IDLE;
        else gcnt_d = gcnt_q - GW'(1);
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk400 or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      trig_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      trig_q  <= trig_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  assign trigger_out = trig_q;
  assign busy        = state_q != S_IDLE;
  assign drop        = drop_q;
  assign drop_cnt    = cnt_q;
endmodule

// File: tb/tb_trigger_out_async.sv
// tb_trigger_out_async: directed requests checked every clk400 cycle against an interval model of the pulse schedule.
module tb_trigger_out_async;
  logic clk400 = 0, clk80 = 0, reset = 1, sync = 0, trg_req = 0;
  logic [3:0] trg_pos = 0;
  logic trigger_out, busy, drop;
  logic [7:0] drop_cnt;
  int n = -1, k = -1, n_chk = 0, n_fail = 0;
  int q_e0[$], q_pos[$];
  bit acc = 0, m_drop, m_trig, m_busy, prev = 0;
  int a_e0 = 0, a_rise = 0, free_at = 0, m_cnt = 0, rise_n = -1, width = 0;

  trigger_out_async dut (
    .clk400(clk400), .reset(reset), .clk80(clk80), .sync(sync),
    .trg_req(trg_req), .trg_pos(trg_pos), .trigger_out(trigger_out),
    .busy(busy), .drop(drop), .drop_cnt(drop_cnt)
  );

  // clk400 rises at 10n+5; clk80 rises at 6+50k, so clk400 edge 5k+1 is the first after it
  always #5 clk400 = ~clk400;
  initial begin
    #6;
    forever begin
      clk80 = 1; #25;
      clk80 = 0; #25;
    end
  end
  always @(posedge clk400) n++;
  always @(posedge clk80) begin
    #2;
    k++;
    sync = (k % 2 == 1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // a request presented in sync cycle k is captured at the end of k and used at edge 5*(k+2)+2
  task automatic send(input int p, output int e0);
    @(posedge sync);
    trg_req = 1;
    trg_pos = 4'(p);
    e0 = 5 * k + 12;
    q_e0.push_back(e0);
    q_pos.push_back(p > 9 ? 9 : p);
    @(negedge sync);
    trg_req = 0;
  endtask

  task automatic wait_n(input int m);
    while (n < m) @(negedge clk400);
  endtask

  always @(negedge clk400) begin
    if (reset) begin
      q_e0.delete();
      q_pos.delete();
      acc = 0; free_at = 0; m_cnt = 0; prev = 0;
    end else begin
      m_drop = 0;
      if (q_e0.size() > 0 && q_e0[0] == n) begin
        int e, p;
        e = q_e0.pop_front();
        p = q_pos.pop_front();
        if (n >= free_at) begin
          acc = 1; a_e0 = e; a_rise = e + p; free_at = a_rise + 16;
        end else begin
          m_drop = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      m_trig = acc && n >= a_rise && n < a_rise + 5;
      m_busy = acc && n >= a_e0 && n < a_rise + 15;
      chk("trigger_out", trigger_out, m_trig);
      chk("busy", busy, m_busy);
      chk("drop", drop, m_drop);
      chk("drop_cnt", drop_cnt, m_cnt);
      if (trigger_out && !prev) begin
        rise_n = n;
        width = 0;
      end
      if (trigger_out) width++;
      prev = trigger_out;
    end
  end

  initial begin
    int e0, e1;
    #1;
    chk("rst_trigger", trigger_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_cnt", drop_cnt, 0);
    #33 reset = 0;
    repeat (4) @(negedge clk400);
    send(0, e0);
    wait_n(e0 + 20);
    chk("t1_offset", rise_n - e0, 0);
    chk("t1_width", width, 5);
    send(9, e0);
    wait_n(e0 + 30);
    chk("t2_offset", rise_n - e0, 9);
    chk("t2_width", width, 5);
    chk("t2_cnt", drop_cnt, 0);
    send(12, e0);
    wait_n(e0 + 30);
    chk("t3_offset", rise_n - e0, 9);
    chk("t3_width", width, 5);
    send(9, e0);
    send(9, e1);
    wait_n(e1 + 30);
    chk("t4_cnt", drop_cnt, 1);
    chk("t4_single", rise_n - e0, 9);
    repeat (300) begin
      send(9, e0);
      send(9, e1);
    end
    wait_n(e1 + 30);
    chk("t4_sat", drop_cnt, 255);
    for (int p = 0; p < 10; p++) begin
      send(p, e0);
      wait_n(e0 + 30);
      chk("t6_offset", rise_n - e0, p);
      chk("t6_width", width, 5);
    end
    send(0, e0);
    wait_n(e0 + 2);
    chk("t5_high", trigger_out, 1);
    #1 reset = 1;
    #1;
    chk("t5_async_trig", trigger_out, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_cnt", drop_cnt, 0);
    repeat (3) @(negedge clk400);
    reset = 0;
    repeat (40) @(negedge clk400);
    chk("t5_no_pulse", rise_n, e0);
    send(3, e0);
    wait_n(e0 + 30);
    chk("t5_after", rise_n - e0, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
